bcd_display_scan: RTL
=====================

BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

Interface
REQ-001 Parameter SCAN_DIV, default 1000, clk cycles each digit stays selected; legal range 2..65535.
REQ-002 clk  input  1  Single clock; all state updates on rising edge.
REQ-003 clr_n  input  1  Asynchronous active-low reset.
REQ-004 load  input  1  Sampled high: capture q_in into the display latch.
REQ-005 q_in  input  24  Six BCD digits from the counter chain; [3:0] is digit 0 (least significant), [23:20] is digit 5.
REQ-006 seg  output  7  Segment drive, active-high, bit order {g,f,e,d,c,b,a}; registered.
REQ-007 an  output  6  Digit select, one-hot active-low, an[k] selects digit k; registered.
REQ-008 bcd_err  output  1  Sticky flag: the latched value contains a nibble greater than 9; registered.

Function
REQ-009 Display latch (24 bit) shall load q_in on every rising edge with load=1; otherwise it shall hold; q_in shall never reach seg directly.
REQ-010 Prescaler shall count 0..SCAN_DIV-1 and wrap to 0; the terminal count (SCAN_DIV-1) is the advance tick.
REQ-011 Digit index shall increment on each advance tick, sequence 0,1,2,3,4,5,0 (wrap 5->0); it shall not change otherwise.
REQ-012 Each cycle an shall register the one-hot-low code of the current index and seg the decode of the current latch nibble at that index; latency 1 cycle from an index or latch change to an/seg.
REQ-013 Result: seg reflects a load 2 edges after load is sampled (latch edge, then output edge), regardless of the scan position.
REQ-014 Decode: 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F (hex); nibbles A..F shall show dash 40.
REQ-015 bcd_err shall be set on the edge after a load whose q_in holds any nibble >9, and cleared on the edge after a load whose q_in holds no such nibble; it holds otherwise.
REQ-016 Simultaneous load and advance tick: both take effect on the same edge; the next output edge shows the new index with the new latch data.
REQ-017 load held high continuously: the latch tracks q_in every cycle; the scan is unaffected.
REQ-018 an shall never have more than one bit low at any cycle.

Reset
REQ-019 clr_n low shall immediately force latch=0, prescaler=0, index=0, an=6'b111111, seg=7'h00, bcd_err=0.
REQ-020 First edge after clr_n release: an=6'b111110, seg=7'h3F; the scan then proceeds per REQ-010/011.
REQ-021 clr_n asserted mid-scan or mid-load shall abort all state; no partial latch value is retained.

Configuration
REQ-022 Macro LEADING_ZERO_BLANK_EN, when defined: digit k (k=1..5) shall output seg=7'h00 when latch digits k..5 are all zero; an still selects it; digit 0 is never blanked; a dash nibble is not zero and stops blanking.
REQ-023 Without LEADING_ZERO_BLANK_EN, every digit shall be decoded per REQ-014; no blanking logic is present.

Verification (SCAN_DIV=4)
REQ-024 Reset release, no load -> an cycles 111110,111101,...,011111, each held 4 cycles, then wraps; seg=3F throughout (macro off).
REQ-025 load=1 one cycle with q_in=24'h123456 -> 2 edges later seg follows the active digit: digit0=7D, digit1=6D, digit2=66, digit3=4F, digit4=5B, digit5=06; bcd_err=0.
REQ-026 Load q_in=24'h00A009 -> digit3 shows 40, bcd_err=1; then load 24'h000000 -> bcd_err=0 the edge after that load.
REQ-027 Macro on, load 24'h000120 -> digits 5,4,3 seg=00, digit2=06, digit1=5B, digit0=3F; load 24'h000000 -> only digit0 lit (3F).
REQ-028 clr_n pulsed low while an=110111 -> an=111111 and seg=00 asynchronously; after release the scan restarts at digit0 with seg=3F.
REQ-029 load asserted exactly on the prescaler terminal count -> on the next output edge an advances and seg shows the new value's digit for the new index.

Source files
------------

// File: rtl/bcd_display_scan.sv
// rtl/bcd_display_scan.sv - six-digit multiplexed BCD display scanner; optional LEADING_ZERO_BLANK_EN
module bcd_display_scan #(
  parameter int SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        load,
  input  logic [23:0] q_in,
  output logic [6:0]  seg,
  output logic [5:0]  an,
  output logic        bcd_err
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [2:0]    IDX_LAST   = 3'd5;
  localparam logic [6:0]    SEG_DASH   = 7'h40;

  logic [23:0]   latch_q, latch_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [5:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          err_q, err_d;

  logic          tick;
  logic [3:0]    cur_nib;
  logic [6:0]    cur_seg;

  // Seven-segment decode, {g,f,e,d,c,b,a}; non-BCD nibbles show a dash.
  function automatic logic [6:0] decode_nib(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  // True when any of the six nibbles is outside 0..9.
  function automatic logic has_bad_nib(input logic [23:0] v);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (v[4*k +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Prescaler: the terminal count is the digit advance tick.
  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  // Digit index walks 0..5 and wraps, moving only on a tick.
  always_comb begin
    idx_d = idx_q;
    if (tick) idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
  end

  // Display latch and error flag both follow q_in only on a load.
  always_comb begin
    latch_d = latch_q;
    err_d   = err_q;
    if (load) begin
      latch_d = q_in;
      err_d   = has_bad_nib(q_in);
    end
  end

  // Select the latched nibble for the digit currently being scanned.
  always_comb begin
    cur_nib = 4'd0;
    case (idx_q)
      3'd0:    cur_nib = latch_q[3:0];
      3'd1:    cur_nib = latch_q[7:4];
      3'd2:    cur_nib = latch_q[11:8];
      3'd3:    cur_nib = latch_q[15:12];
      3'd4:    cur_nib = latch_q[19:16];
      3'd5:    cur_nib = latch_q[23:20];
      default: cur_nib = 4'd0;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [5:0] zero_from;

  // zero_from[k]: latch digits k..5 are all zero, so digit k is a leading zero.
  always_comb begin
    zero_from[5] = (latch_q[23:20] == 4'd0);
    for (int k = 4; k >= 0; k--) begin
      zero_from[k] = zero_from[k+1] && (latch_q[4*k +: 4] == 4'd0);
    end
  end

  // Decode, blanking leading zeros on every digit except the units digit.
  always_comb begin
    cur_seg = decode_nib(cur_nib);
    if ((idx_q != 3'd0) && (idx_q <= IDX_LAST) && zero_from[idx_q]) cur_seg = 7'h00;
  end
`else
  // Plain decode of the selected digit.
  always_comb begin
    cur_seg = decode_nib(cur_nib);
  end
`endif

  // Output stage: one-hot-low digit select plus segments for the current index.
  always_comb begin
    an_d  = 6'b111111;
    seg_d = cur_seg;
    if (idx_q <= IDX_LAST) an_d = ~(6'b000001 << idx_q);
  end

  // State register; reset clears everything, including the display outputs.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      latch_q <= '0;
      presc_q <= '0;
      idx_q   <= 3'd0;
      an_q    <= 6'b111111;
      seg_q   <= 7'h00;
      err_q   <= 1'b0;
    end else begin
      latch_q <= latch_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      err_q   <= err_d;
    end
  end

  assign seg     = seg_q;
  assign an      = an_q;
  assign bcd_err = err_q;

endmodule
